// File: rtl/alu_serial_if.sv
// Request/response bundle for the bit-serial ALU.
// The master drives the operands and start; the slave drives status and results.
interface alu_serial_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [2:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             carryout;
    logic             overflow;
    logic             zero;

    modport master (
        output start, op, a, b,
        input  busy, done, result, carryout, overflow, zero
    );

    modport slave (
        input  start, op, a, b,
        output busy, done, result, carryout, overflow, zero
    );
endinterface

// File: rtl/alu_serial.sv
// Bit-serial ALU: one result bit per clock through a single 1-bit slice with a
// registered carry, LSB first. Operands are latched on the accepting edge.
module alu_serial #(
    parameter int WIDTH = 32
) (
    input  logic       clk,
    input  logic       reset,
    alu_serial_if.slave bus
);
    localparam int CW = $clog2(WIDTH);

    localparam logic [2:0] OP_ADD  = 3'b000;
    localparam logic [2:0] OP_SUB  = 3'b001;
    localparam logic [2:0] OP_XOR  = 3'b010;
    localparam logic [2:0] OP_SLT  = 3'b011;
    localparam logic [2:0] OP_AND  = 3'b100;
    localparam logic [2:0] OP_NAND = 3'b101;
    localparam logic [2:0] OP_NOR  = 3'b110;
    localparam logic [2:0] OP_OR   = 3'b111;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, b_q, res_q;
    logic [2:0]       op_q;
    logic [CW-1:0]    cnt_q;
    logic             carry_q, co_q, ov_q, zero_q;

    logic             load_s, last_s, sub_s, arith_s;
    logic             ai_s, bx_s, sum_s, cout_s, ovf_s, bit_s;
    logic [WIDTH-1:0] final_s;

    assign last_s = (cnt_q == CW'(WIDTH - 1));

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state decode; start is only honoured outside RUN
    always_comb begin
        state_d = state_q;
        load_s  = 1'b0;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (bus.start) begin
                    state_d = S_RUN;
                    load_s  = 1'b1;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_RUN: begin
                if (last_s) begin
                    state_d = S_DONE;
                end else begin
                    state_d = S_RUN;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // 1-bit slice; subtraction is a + ~b + 1 with the +1 preloaded into carry
    always_comb begin
        sub_s   = (op_q == OP_SUB) || (op_q == OP_SLT);
        arith_s = (op_q == OP_ADD) || (op_q == OP_SUB);
        ai_s    = a_q[0];
        bx_s    = b_q[0] ^ sub_s;
        sum_s   = ai_s ^ bx_s ^ carry_q;
        cout_s  = (ai_s & bx_s) | (carry_q & (ai_s ^ bx_s));
        ovf_s   = carry_q ^ cout_s;
        case (op_q)
            OP_ADD, OP_SUB, OP_SLT: bit_s = sum_s;
            OP_XOR:                 bit_s = ai_s ^ b_q[0];
            OP_AND:                 bit_s = ai_s & b_q[0];
            OP_NAND:                bit_s = ~(ai_s & b_q[0]);
            OP_NOR:                 bit_s = ~(ai_s | b_q[0]);
            OP_OR:                  bit_s = ai_s | b_q[0];
            default:                bit_s = 1'b0;
        endcase
        if (op_q == OP_SLT) begin
            final_s = {{(WIDTH-1){1'b0}}, sum_s ^ ovf_s};
        end else begin
            final_s = {bit_s, res_q[WIDTH-1:1]};
        end
    end

    // Operand latch, serial shift and result/flag capture on the last bit
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= 3'b000;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            res_q   <= '0;
            co_q    <= 1'b0;
            ov_q    <= 1'b0;
            zero_q  <= 1'b1;
        end else if (load_s) begin
            a_q     <= bus.a;
            b_q     <= bus.b;
            op_q    <= bus.op;
            cnt_q   <= '0;
            carry_q <= (bus.op == OP_SUB) || (bus.op == OP_SLT);
        end else if (state_q == S_RUN) begin
            a_q     <= a_q >> 1;
            b_q     <= b_q >> 1;
            carry_q <= cout_s;
            cnt_q   <= cnt_q + CW'(1);
            if (last_s) begin
                res_q  <= final_s;
                co_q   <= arith_s & cout_s;
                ov_q   <= arith_s & ovf_s;
                zero_q <= (final_s == '0);
            end else begin
                res_q  <= {bit_s, res_q[WIDTH-1:1]};
            end
        end
    end

    assign bus.busy     = (state_q == S_RUN);
    assign bus.done     = (state_q == S_DONE);
    assign bus.result   = res_q;
    assign bus.carryout = co_q;
    assign bus.overflow = ov_q;
    assign bus.zero     = zero_q;
endmodule

// File: tb/tb_alu_serial.sv
// Directed bench for alu_serial (WIDTH=32) with hand-computed expectations.
module tb_alu_serial;
    logic clk;
    logic reset;
    int   tests;
    int   fails;

    alu_serial_if #(.WIDTH(32)) bus ();

    alu_serial #(.WIDTH(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Called #1 after a rising edge; start is raised for exactly one edge.
    task automatic run_op(input string tag, input logic [2:0] o, input logic [31:0] av,
                          input logic [31:0] bv, input logic [31:0] er, input logic ec,
                          input logic eo, input logic ez, input bit poke);
        int n;
        bus.start = 1'b1;
        bus.op    = o;
        bus.a     = av;
        bus.b     = bv;
        @(posedge clk); #1;
        check({tag, ".busy"}, {31'd0, bus.busy}, 32'd1);
        bus.start = 1'b0;
        bus.op    = ~o;
        bus.a     = $urandom;
        bus.b     = $urandom;
        n = 0;
        while (!bus.done && n < 100) begin
            if (poke && n == 5) begin
                bus.start = 1'b1;
                bus.op    = 3'b000;
                bus.a     = 32'h0000_1234;
                bus.b     = 32'h0000_4321;
            end else begin
                bus.start = 1'b0;
            end
            @(posedge clk); #1;
            n++;
        end
        bus.start = 1'b0;
        check({tag, ".lat"}, 32'(n), 32'd32);
        check({tag, ".res"}, bus.result, er);
        check({tag, ".co"},  {31'd0, bus.carryout}, {31'd0, ec});
        check({tag, ".ov"},  {31'd0, bus.overflow}, {31'd0, eo});
        check({tag, ".z"},   {31'd0, bus.zero}, {31'd0, ez});
    endtask

    initial begin
        bit seen;
        tests     = 0;
        fails     = 0;
        reset     = 1'b1;
        bus.start = 1'b0;
        bus.op    = 3'b000;
        bus.a     = 32'd0;
        bus.b     = 32'd0;
        repeat (2) @(posedge clk);
        #1;
        check("rst.busy", {31'd0, bus.busy}, 32'd0);
        check("rst.done", {31'd0, bus.done}, 32'd0);
        check("rst.res",  bus.result, 32'd0);
        check("rst.z",    {31'd0, bus.zero}, 32'd1);
        check("rst.co",   {31'd0, bus.carryout}, 32'd0);
        check("rst.ov",   {31'd0, bus.overflow}, 32'd0);
        reset = 1'b0;

        run_op("add_wrap", 3'b000, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b1, 1'b0, 1'b1, 1'b0);
        @(posedge clk); #1;
        check("done.pulse", {31'd0, bus.done}, 32'd0);
        check("hold.res",   bus.result, 32'h0000_0000);
        check("hold.co",    {31'd0, bus.carryout}, 32'd1);

        // Consecutive calls start in the DONE cycle (back-to-back acceptance)
        run_op("sub_ovf",  3'b001, 32'h8000_0000, 32'h0000_0001, 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0, 1'b0);
        run_op("add_ovf",  3'b000, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 1'b0, 1'b1, 1'b0, 1'b0);
        run_op("slt_m1_1", 3'b011, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001, 1'b0, 1'b0, 1'b0, 1'b0);
        run_op("slt_1_m1", 3'b011, 32'h0000_0001, 32'hFFFF_FFFF, 32'h0000_0000, 1'b0, 1'b0, 1'b1, 1'b0);
        run_op("slt_min",  3'b011, 32'h8000_0000, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 1'b0, 1'b0);
        run_op("and",      3'b100, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000, 1'b0, 1'b0, 1'b0, 1'b0);
        run_op("nand",     3'b101, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'h0FFF_0FFF, 1'b0, 1'b0, 1'b0, 1'b0);
        run_op("nor",      3'b110, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'h000F_000F, 1'b0, 1'b0, 1'b0, 1'b0);
        run_op("or",       3'b111, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hFFF0_FFF0, 1'b0, 1'b0, 1'b0, 1'b0);
        run_op("xor",      3'b010, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'h0FF0_0FF0, 1'b0, 1'b0, 1'b0, 1'b0);
        run_op("poke_run", 3'b001, 32'h0000_0064, 32'h0000_0001, 32'h0000_0063, 1'b1, 1'b0, 1'b0, 1'b1);
        @(posedge clk); #1;
        check("idle.busy", {31'd0, bus.busy}, 32'd0);

        // Reset in the middle of a run
        bus.start = 1'b1;
        bus.op    = 3'b000;
        bus.a     = 32'h1111_1111;
        bus.b     = 32'h2222_2222;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (11) @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        check("midrst.busy", {31'd0, bus.busy}, 32'd0);
        check("midrst.res",  bus.result, 32'd0);
        check("midrst.z",    {31'd0, bus.zero}, 32'd1);
        @(posedge clk); #1;
        reset = 1'b0;
        seen  = 1'b0;
        repeat (40) begin
            @(posedge clk); #1;
            if (bus.done) seen = 1'b1;
        end
        check("midrst.nodone", {31'd0, seen}, 32'd0);
        run_op("add_3_4", 3'b000, 32'h0000_0003, 32'h0000_0004, 32'h0000_0007, 1'b0, 1'b0, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
